// File: rtl/fwd_agent.sv
// Forwarding agent: reads a packet out of the word-addressed buffer and replays it
// on a 64-bit egress stream, handshaking job start/finish with the controller.
module fwd_agent #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy_for_C,
  output logic                    rdy_for_C_ack,
  output logic                    C_done,
  input  logic                    C_done_ack,
  input  logic [ADDR_WIDTH+2:0]   byte_len,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic [DATA_WIDTH/8-1:0] tkeep,
  output logic                    tvalid,
  output logic                    tlast,
  input  logic                    tready
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int CNT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        n_words;
  logic [CNT_W-1:0]        req_cnt;
  logic [CNT_W-1:0]        req_nxt;
  logic [KEEP_W-1:0]       last_keep;
  logic [ADDR_WIDTH+3:0]   len_rnd;
  logic                    accept;
  logic                    pop;
  logic [2:0]              occ;

  logic                    vld_p1;
  logic                    last_p1;
  logic [KEEP_W-1:0]       keep_p1;

  logic                    tail_vld;
  logic [DATA_WIDTH-1:0]   tail_data;
  logic [KEEP_W-1:0]       tail_keep;
  logic                    tail_last;

  function automatic logic [KEEP_W-1:0] last_keep_f(input logic [2:0] rem);
    if (rem == 3'd0) return '1;
    return KEEP_W'((9'd1 << rem) - 9'd1);
  endfunction

  assign rdy_for_C_ack = (state == IDLE) && !rst;
  assign C_done        = (state == DONE) && !rst;
  assign accept        = rdy_for_C && rdy_for_C_ack;
  assign pop           = tvalid && tready;
  assign len_rnd       = {1'b0, byte_len} + (ADDR_WIDTH+4)'(7);
  assign req_nxt       = req_cnt + CNT_W'(1);
  assign keep_p1       = last_p1 ? last_keep : '1;

  // FIFO occupancy plus the read in flight must leave room for the next return
  assign occ   = {1'b0, tvalid} + {2'b00, tail_vld} + {2'b00, vld_p1};
  assign rd_en = !rst && (state == RUN) && (req_cnt < n_words)
              && (occ < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_words   <= '0;
      req_cnt   <= '0;
      rd_addr   <= '0;
      last_keep <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      tvalid    <= 1'b0;
      tlast     <= 1'b0;
      tkeep     <= '0;
      tdata     <= '0;
      tail_vld  <= 1'b0;
    end else begin
      // read issue -> data return (p1)
      vld_p1 <= rd_en;
      if (rd_en) last_p1 <= (req_nxt == n_words);

      case (state)
        IDLE: if (accept) begin
          n_words   <= len_rnd[ADDR_WIDTH+3:3];
          last_keep <= last_keep_f(byte_len[2:0]);
          req_cnt   <= '0;
          rd_addr   <= '0;
          state     <= (byte_len == '0) ? DONE : RUN;
        end
        RUN: begin
          if (rd_en) begin
            req_cnt <= req_nxt;
            if (req_nxt != n_words) rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
          if (pop && tlast) state <= DONE;
        end
        DONE: if (C_done_ack) state <= IDLE;
        default: state <= IDLE;
      endcase

      // return (p1) -> two-entry output FIFO; head entry is the stream register
      if (pop) begin
        if (tail_vld) begin
          tdata  <= tail_data;
          tkeep  <= tail_keep;
          tlast  <= tail_last;
          tvalid <= 1'b1;
          if (vld_p1) begin
            tail_data <= rd_data;
            tail_keep <= keep_p1;
            tail_last <= last_p1;
          end
          tail_vld <= vld_p1;
        end else if (vld_p1) begin
          tdata  <= rd_data;
          tkeep  <= keep_p1;
          tlast  <= last_p1;
          tvalid <= 1'b1;
        end else begin
          tvalid <= 1'b0;
        end
      end else if (vld_p1) begin
        if (!tvalid) begin
          tdata  <= rd_data;
          tkeep  <= keep_p1;
          tlast  <= last_p1;
          tvalid <= 1'b1;
        end else begin
          tail_data <= rd_data;
          tail_keep <= keep_p1;
          tail_last <= last_p1;
          tail_vld  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/fwd_agent.md
FWD_AGENT -- requirements
Module: fwd_agent

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the packet-buffer word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, fixed at 64, meaning the buffer read width and stream width, 8 bytes per word.
REQ-003 SHALL have clk, input, 1, the clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have rst, input, 1, the synchronous active-high reset.
REQ-005 SHALL have rdy_for_C, input, 1, a level from the controller: a buffer is available to forward.
REQ-006 SHALL have rdy_for_C_ack, output, 1, the agent's acceptance of rdy_for_C.
REQ-007 SHALL have C_done, output, 1, indicating the agent has finished the buffer.
REQ-008 SHALL have C_done_ack, input, 1, the controller's acceptance of C_done.
REQ-009 SHALL have byte_len, input, ADDR_WIDTH+3, the packet length in bytes, valid while rdy_for_C is high.
REQ-010 SHALL have rd_en, output, 1, the buffer read strobe.
REQ-011 SHALL have rd_addr, output, ADDR_WIDTH, the buffer word address.
REQ-012 SHALL have rd_data, input, 64, the buffer data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have tdata/tkeep/tvalid/tlast, outputs of 64/8/1/1, and tready, input, 1, forming the egress stream.

Function
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 SHALL drive rdy_for_C_ack = (state==IDLE) && !rst, combinationally.
REQ-016 SHALL treat a cycle with rdy_for_C && rdy_for_C_ack as an accept: latch byte_len, set the word counters, and set rd_addr to 0.
REQ-017 SHALL move IDLE->RUN on an accept with byte_len!=0, and IDLE->DONE on an accept with byte_len==0, issuing no reads and no beats.
REQ-018 SHALL set the word count to N=ceil(byte_len/8); the maximum is 2^ADDR_WIDTH words, and rd_addr never wraps.
REQ-019 SHALL hold a 2-entry output FIFO; in RUN, rd_en SHALL be asserted iff requested<N and (fifo_count + inflight - pop) < 2, where pop = tvalid&&tready.
REQ-020 SHALL increment rd_addr by 1 after each rd_en; the first read is in the cycle after the accept.
REQ-021 SHALL push rd_data into the FIFO in the cycle it is valid, and SHALL drive tvalid/tdata from the FIFO head, with registered outputs.
REQ-022 SHALL hold tdata/tkeep/tlast stable while tvalid && !tready.
REQ-023 SHALL assert tlast only on beat N.
REQ-024 SHALL set tkeep to 8'hFF on every beat except beat N; on beat N, tkeep SHALL be (1<<(byte_len%8))-1, or 8'hFF when byte_len%8==0, with the LSB as the first byte.
REQ-025 SHALL, with tready held high, raise the first tvalid 3 cycles after the accept cycle and then stream 1 beat per cycle.
REQ-026 SHALL move RUN->DONE in the cycle after the handshake of the tlast beat.
REQ-027 SHALL hold C_done = (state==DONE), and SHALL move DONE->IDLE in a cycle with C_done && C_done_ack.
REQ-028 SHALL hold C_done high for as long as C_done_ack stays low.
REQ-029 SHALL ignore rdy_for_C outside IDLE, and SHALL never assert rdy_for_C_ack together with C_done.
REQ-030 SHALL permit a back-to-back job: an accept in the first IDLE cycle after DONE.

Reset
REQ-031 SHALL, on rst, set state=IDLE, flush the FIFO, clear inflight and counters, set rd_addr to 0, and drive rd_en, tvalid, tlast, C_done and rdy_for_C_ack to 0, with tkeep=8'h00 and tdata=0.
REQ-032 SHALL abort any job when rst is asserted mid-operation, with no further beats or reads, and SHALL allow an accept in the first cycle after rst deasserts.

Verification
REQ-033 SHALL cover: byte_len=20, tready=1 -> rd_en asserted for 3 cycles with addrs 0,1,2, then beats at accept+3..+5, beat 3 tlast=1 tkeep=8'h0F, then C_done 1 cycle later.
REQ-034 SHALL cover: byte_len=16, tready toggling 1/0 -> 2 beats with data unchanged during stalls, last beat tkeep=8'hFF, and no more than 2 reads ahead of pops.
REQ-035 SHALL cover: byte_len=0 -> rd_en and tvalid never asserted, and C_done high in the cycle after the accept.
REQ-036 SHALL cover: C_done_ack held low for 5 cycles -> C_done held for 5 cycles, rdy_for_C_ack=0 throughout, and IDLE in the cycle after the ack.
REQ-037 SHALL cover: rst asserted while beat 2 of 4 is stalled -> tvalid=0 and C_done=0 in the next cycle, then a new accept with byte_len=8 yields 1 beat with tkeep=8'hFF.
REQ-038 SHALL cover: byte_len=2^(ADDR_WIDTH+3)-1 -> 2^ADDR_WIDTH beats, final rd_addr=2^ADDR_WIDTH-1, and last tkeep=8'h7F.
